// File: rtl/edge_pkg.sv
// Shared types and widths for the edge point extraction slice.
// Holds the coordinate width, FIFO word width and frame FSM encoding.
package edge_pkg;

    localparam int COORD_W = 12;
    localparam int PT_W    = 2 * COORD_W;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ACTIVE  = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// Ports: clk, rst_n, push/din (write), pop (read), dout (head word),
// empty, full. A push while full is taken only if a pop happens in the
// same cycle.
module sync_fifo_fwft #(
    parameter int DW    = 24,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/edge_point_extract.sv
// Turns binarised Sobel edge pixels inside an ROI into (x, y) points,
// queues them in a FWFT FIFO and hands them out on valid/ready.
// Inputs : clk, rst_n, sobel_de, sobel_vsync, sobel_data[7:0], pt_ready.
// Outputs: pt_valid, pt_x, pt_y (head point), frame_done (1-cycle pulse
//          once a frame's points are all popped), overflow (sticky),
//          drop_cnt (saturating count of dropped points this frame).
module edge_point_extract
    import edge_pkg::*;
#(
    parameter int H_DISP     = 640,
    parameter int V_DISP     = 480,
    parameter int ROI_Y_TOP  = 240,
    parameter int ROI_X_L    = 0,
    parameter int ROI_X_R    = 639,
    parameter int FIFO_DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sobel_de,
    input  logic               sobel_vsync,
    input  logic [7:0]         sobel_data,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    output logic               frame_done,
    output logic               overflow,
    output logic [15:0]        drop_cnt
);

    // Columns past the end of a line never occur, so clamp the right edge.
    localparam int XR_I = (ROI_X_R < H_DISP) ? ROI_X_R : H_DISP - 1;
    localparam logic [COORD_W-1:0] X_MAX  = '1;
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_DISP - 1);

    state_t             state;
    state_t             state_nxt;
    logic               pending;
    logic               pending_nxt;
    logic               stat_clr;
    logic               de_q;
    logic               vs_q;
    logic               de_fall;
    logic               vs_rise;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic               x_lo_ok;
    logic               y_ok;
    logic               x_hi_ok;
    logic               qualify;
    logic               pv_q;
    logic [PT_W-1:0]    pt_q;
    logic               pop;
    logic               drop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [PT_W-1:0]    fifo_dout;
    logic               data_unused;

    assign data_unused = ^sobel_data[6:0];

    assign de_fall = de_q & ~sobel_de;
    assign vs_rise = sobel_vsync & ~vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q  <= 1'b0;
            vs_q  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            de_q <= sobel_de;
            vs_q <= sobel_vsync;
            if (de_fall) begin
                x_cnt <= '0;
            end else if (sobel_de && x_cnt != X_MAX) begin
                x_cnt <= x_cnt + COORD_W'(1);
            end
            if (vs_rise) begin
                y_cnt <= '0;
            end else if (de_fall) begin
                y_cnt <= y_cnt + COORD_W'(1);
            end
        end
    end

    // A zero lower bound is always met; skip the compare entirely.
    if (ROI_X_L == 0) begin : g_xl_any
        assign x_lo_ok = 1'b1;
    end else begin : g_xl_cmp
        assign x_lo_ok = (x_cnt >= COORD_W'(ROI_X_L));
    end

    if (ROI_Y_TOP == 0) begin : g_yt_any
        assign y_ok = 1'b1;
    end else begin : g_yt_cmp
        assign y_ok = (y_cnt >= COORD_W'(ROI_Y_TOP));
    end

    assign x_hi_ok = (x_cnt <= COORD_W'(XR_I));
    assign qualify = sobel_de & sobel_data[7] & y_ok & x_lo_ok
                   & x_hi_ok & (state == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= 1'b0;
            pt_q <= '0;
        end else begin
            pv_q <= qualify;
            if (qualify) begin
                pt_q <= {y_cnt, x_cnt};
            end
        end
    end

    assign pt_valid = ~fifo_empty;
    assign pop      = pt_valid & pt_ready;
    assign drop     = pv_q & fifo_full & ~pop;

    sync_fifo_fwft #(
        .DW    (PT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pv_q),
        .pop   (pop),
        .din   (pt_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Unread RAM contents stay off the bus while nothing is queued.
    assign {pt_y, pt_x} = fifo_empty ? '0 : fifo_dout;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        frame_done  = 1'b0;
        stat_clr    = 1'b0;
        unique case (state)
            WAIT_VS: begin
                if (vs_rise) begin
                    state_nxt = ACTIVE;
                    stat_clr  = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_nxt   = DRAIN;
                    pending_nxt = 1'b1;
                end else if (de_fall && y_cnt == Y_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (vs_rise) begin
                    pending_nxt = 1'b1;
                end
                // Done only once the pipeline register is empty too.
                if (fifo_empty && !pv_q) begin
                    frame_done = 1'b1;
                    if (pending || vs_rise) begin
                        state_nxt   = ACTIVE;
                        pending_nxt = 1'b0;
                        stat_clr    = 1'b1;
                    end else begin
                        state_nxt = WAIT_VS;
                    end
                end
            end
            default: state_nxt = WAIT_VS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_VS;
            pending  <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (stat_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule
